// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian word stream into instruction memory,
// verifies an XOR checksum, then releases the core from reset.
module imem_boot_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 imem_we,
  output logic [31:0]          imem_waddr,
  output logic [31:0]          imem_wdata,
  output logic                 core_reset_n,
  output logic                 load_done,
  output logic                 load_error,
  output logic [CNT_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } loadState_t;

  loadState_t           state, nextState;
  logic                 armed;
  logic [7:0]           cntLo;
  logic [CNT_WIDTH-1:0] wordCount;
  logic [CNT_WIDTH-1:0] hdrCount;
  logic [1:0]           lane;
  logic [23:0]          wordBuf;
  logic [7:0]           runXor;
  logic                 loading;
  logic                 transfer;
  logic                 writeWord;
  logic                 lastWord;

  // armed keeps byte_ready low until the first clock edge after reset release
  assign loading    = (state == CNT_LO) || (state == CNT_HI) ||
                      (state == DATA)   || (state == CSUM);
  assign byte_ready = armed && loading;
  assign transfer   = byte_valid && byte_ready;
  assign hdrCount   = CNT_WIDTH'({byte_data, cntLo});
  assign lastWord   = ((words_loaded + CNT_WIDTH'(1)) == wordCount);

  always_comb begin
    nextState = state;
    writeWord = 1'b0;
    case (state)
      CNT_LO: begin
        if (transfer) nextState = CNT_HI;
      end
      CNT_HI: begin
        if (transfer) begin
          if (hdrCount > CNT_WIDTH'(DEPTH_WORDS)) nextState = ERROR;
          else if (hdrCount == '0)                 nextState = CSUM;
          else                                     nextState = DATA;
        end
      end
      DATA: begin
        if (transfer && (lane == 2'd3)) begin
          writeWord = 1'b1;
          if (lastWord) nextState = CSUM;
        end
      end
      CSUM: begin
        if (transfer) nextState = (byte_data == runXor) ? RUN : ERROR;
      end
      default: nextState = state;
    endcase
  end

  // Datapath and sticky status; the checksum byte itself never enters runXor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CNT_LO;
      armed        <= 1'b0;
      cntLo        <= '0;
      wordCount    <= '0;
      lane         <= '0;
      wordBuf      <= '0;
      runXor       <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      state   <= nextState;
      armed   <= 1'b1;
      imem_we <= writeWord;
      if (transfer && (state != CSUM)) runXor <= runXor ^ byte_data;
      if (transfer && (state == CNT_LO)) cntLo <= byte_data;
      if (transfer && (state == CNT_HI)) wordCount <= hdrCount;
      if (transfer && (state == DATA)) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    wordBuf[7:0]   <= byte_data;
          2'd1:    wordBuf[15:8]  <= byte_data;
          2'd2:    wordBuf[23:16] <= byte_data;
          default: wordBuf        <= wordBuf;
        endcase
      end
      if (writeWord) begin
        imem_waddr   <= 32'({words_loaded, 2'b00});
        imem_wdata   <= {byte_data, wordBuf};
        words_loaded <= words_loaded + CNT_WIDTH'(1);
      end
      if ((state == CSUM) && (nextState == RUN)) load_done <= 1'b1;
      if ((state != ERROR) && (nextState == ERROR)) load_error <= 1'b1;
      if (state == RUN) core_reset_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader: byte streams with hand-computed
// expected writes, status flags and reset behaviour.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_reset_n;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int vectors = 0;
  int misses  = 0;
  int writeCount = 0;
  logic [31:0] wAddr [0:255];
  logic [31:0] wData [0:255];

  imem_boot_loader #(.DEPTH_WORDS(64), .CNT_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n),
    .load_done(load_done),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (writeCount < 256) begin
        wAddr[writeCount] = imem_waddr;
        wData[writeCount] = imem_wdata;
      end
      writeCount = writeCount + 1;
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCnt;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    waitCnt = 0;
    while (byte_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (byte_ready !== 1'b1) begin
      vectors++;
      misses++;
      $display("[TB] FAIL sendByte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'hxx;
  endtask

  task automatic doReset();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("reset_ready", 32'(byte_ready), 32'd0);
    checkVal("reset_we", 32'(imem_we), 32'd0);
    checkVal("reset_waddr", imem_waddr, 32'd0);
    checkVal("reset_wdata", imem_wdata, 32'd0);
    checkVal("reset_corern", 32'(core_reset_n), 32'd0);
    checkVal("reset_done", 32'(load_done), 32'd0);
    checkVal("reset_error", 32'(load_error), 32'd0);
    checkVal("reset_words", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("ready_after_release", 32'(byte_ready), 32'd1);
  endtask

  task automatic test_single_word();
    int base;
    logic [7:0] s [0:6];
    base = writeCount;
    s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    for (int i = 0; i < 7; i++) sendByte(s[i], 0);
    checkVal("single_done", 32'(load_done), 32'd1);
    checkVal("single_corern_entry", 32'(core_reset_n), 32'd0);
    checkVal("single_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    checkVal("single_corern_next", 32'(core_reset_n), 32'd1);
    repeat (3) @(negedge clk);
    checkVal("single_writes", 32'(writeCount - base), 32'd1);
    checkVal("single_addr", wAddr[base], 32'h0);
    checkVal("single_data", wData[base], 32'h00500093);
    checkVal("single_words", 32'(words_loaded), 32'd1);
    checkVal("single_error", 32'(load_error), 32'd0);
  endtask

  task automatic test_bad_checksum();
    int base;
    logic [7:0] s [0:6];
    doReset();
    base = writeCount;
    s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    for (int i = 0; i < 7; i++) sendByte(s[i], 0);
    repeat (3) @(negedge clk);
    checkVal("badcs_done", 32'(load_done), 32'd0);
    checkVal("badcs_error", 32'(load_error), 32'd1);
    checkVal("badcs_corern", 32'(core_reset_n), 32'd0);
    checkVal("badcs_writes", 32'(writeCount - base), 32'd1);
    checkVal("badcs_ready", 32'(byte_ready), 32'd0);
  endtask

  task automatic test_oversize();
    int base;
    doReset();
    base = writeCount;
    sendByte(8'h41, 0);
    sendByte(8'h00, 0);
    checkVal("over_error", 32'(load_error), 32'd1);
    checkVal("over_ready", 32'(byte_ready), 32'd0);
    checkVal("over_done", 32'(load_done), 32'd0);
    repeat (3) @(negedge clk);
    checkVal("over_writes", 32'(writeCount - base), 32'd0);
    checkVal("over_corern", 32'(core_reset_n), 32'd0);
  endtask

  task automatic test_zero_count();
    int base;
    doReset();
    base = writeCount;
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    repeat (2) @(negedge clk);
    checkVal("zero_done", 32'(load_done), 32'd1);
    checkVal("zero_writes", 32'(writeCount - base), 32'd0);
    checkVal("zero_words", 32'(words_loaded), 32'd0);
    checkVal("zero_corern", 32'(core_reset_n), 32'd1);
  endtask

  task automatic test_gapped_words(input int n, input string tag);
    int base;
    logic [7:0] csum;
    logic [31:0] w;
    doReset();
    base = writeCount;
    csum = 8'(n) ^ 8'(n >> 8);
    sendByte(8'(n), $urandom_range(0, 3));
    sendByte(8'(n >> 8), $urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      w = 32'h11223344 ^ (32'(i) * 32'h01030507);
      for (int k = 0; k < 4; k++) begin
        sendByte(w[8*k +: 8], $urandom_range(0, 3));
        csum = csum ^ w[8*k +: 8];
      end
    end
    sendByte(csum, $urandom_range(0, 3));
    repeat (3) @(negedge clk);
    checkVal({tag, "_writes"}, 32'(writeCount - base), 32'(n));
    checkVal({tag, "_words"}, 32'(words_loaded), 32'(n));
    checkVal({tag, "_done"}, 32'(load_done), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < 3 || i == n - 1) begin
        checkVal({tag, "_addr"}, wAddr[base + i], 32'(i * 4));
        checkVal({tag, "_data"}, wData[base + i], 32'h11223344 ^ (32'(i) * 32'h01030507));
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    logic [7:0] s [0:6];
    doReset();
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("mid_ready", 32'(byte_ready), 32'd0);
    checkVal("mid_we", 32'(imem_we), 32'd0);
    checkVal("mid_words", 32'(words_loaded), 32'd0);
    checkVal("mid_done", 32'(load_done), 32'd0);
    checkVal("mid_error", 32'(load_error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    base = writeCount;
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
    for (int i = 0; i < 7; i++) sendByte(s[i], 0);
    repeat (3) @(negedge clk);
    checkVal("mid_reload_writes", 32'(writeCount - base), 32'd1);
    checkVal("mid_reload_addr", wAddr[base], 32'h0);
    checkVal("mid_reload_data", wData[base], 32'h00A00513);
    checkVal("mid_reload_done", 32'(load_done), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_oversize();
    test_zero_count();
    test_gapped_words(3, "three");
    test_gapped_words(64, "full");
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
